intercal_alu_seq: RTL and testbench

Clocked, width-parametrised INTERCAL ALU: the successor of the combinational 32-bit operator unit with byte-serial operand loading. Operands A and B are loaded a byte at a time into registers. A start/busy/done handshake runs one of five INTERCAL operators: mingle, select, unary AND, unary OR, unary XOR. Select runs iteratively, one bit per cycle; the other operators finish in one cycle. The result is held in a register and read whole or by byte.

---
 rtl/intercal_alu_seq.sv | 157 +++++++++++++++
 tb/tb_intercal_alu_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intercal_alu_seq.sv
// Purpose : clocked INTERCAL ALU (mingle, select, unary AND/OR/XOR) with
//           byte-loaded A/B operand registers and byte/whole result readback.
// Latency : 1 edge for mingle/unary/reserved ops; WIDTH edges for select (busy high).
// Backpr. : none; start and operand writes are ignored while busy.
// Ports   : i_clk/i_rst (sync, active-high); i_wr_en/i_wr_b/i_wr_byte/i_wr_data
//           load operand bytes; i_start/i_op launch an op; o_busy/o_done/o_err
//           report status; o_result holds the result; i_rd_byte selects o_rd_data.
module intercal_alu_seq #(
  parameter  int WIDTH = 32,
  localparam int HALF  = WIDTH / 2,
  localparam int BW    = $clog2(WIDTH / 8)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic             i_wr_b,
  input  logic [BW-1:0]    i_wr_byte,
  input  logic [7:0]       i_wr_data,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_result,
  input  logic [BW-1:0]    i_rd_byte,
  output logic [7:0]       o_rd_data
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [WIDTH-1:0] r_wa, r_wb, r_acc;   // select working copies + packed output
  logic [CW-1:0]    r_bit, r_cnt;        // input bit index, next output position
  logic             r_done, r_err;

  logic             w_start_sel, w_start_one, w_last, w_wr_ok;
  logic [WIDTH-1:0] w_ming, w_rot, w_one_res, w_acc_nxt;
  logic             w_one_err;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_start_sel = 1'b0;
    w_start_one = 1'b0;
    w_last      = 1'b0;
    w_wr_ok     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wr_ok = i_wr_en;
        if (i_start) begin
          if (i_op == 3'd1) begin
            w_start_sel = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_start_one = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_bit == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle operators, evaluated on the current (pre-write) operands
  always_comb begin
    w_ming = '0;
    for (int k = 0; k < HALF; k++) begin
      w_ming[2*k+1] = r_a[k];
      w_ming[2*k]   = r_b[k];
    end
    w_rot     = {r_a[0], r_a[WIDTH-1:1]};
    w_one_res = '0;
    w_one_err = 1'b0;
    case (i_op)
      3'd0: begin
        w_one_res = w_ming;
        w_one_err = (|r_a[WIDTH-1:HALF]) | (|r_b[WIDTH-1:HALF]);
      end
      3'd2:    w_one_res = r_a & w_rot;
      3'd3:    w_one_res = r_a | w_rot;
      3'd4:    w_one_res = r_a ^ w_rot;
      default: w_one_err = 1'b1;  // op 1 never reaches here; 5-7 are reserved
    endcase
  end

  // One select step: working copies shift right so bit 0 is always bit i
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_wb[0]) w_acc_nxt[r_cnt] = r_wa[0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_wa     <= '0;
      r_wb     <= '0;
      r_acc    <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_ok) begin
        if (i_wr_b) r_b[8*i_wr_byte +: 8] <= i_wr_data;
        else        r_a[8*i_wr_byte +: 8] <= i_wr_data;
      end
      if (w_start_one) begin
        r_result <= w_one_res;
        r_err    <= w_one_err;
        r_done   <= 1'b1;
      end
      if (w_start_sel) begin
        r_wa  <= r_a;
        r_wb  <= r_b;
        r_acc <= '0;
        r_bit <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_RUN) begin
        r_wa  <= r_wa >> 1;
        r_wb  <= r_wb >> 1;
        r_acc <= w_acc_nxt;
        r_bit <= r_bit + CW'(1);
        if (r_wb[0]) r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_result <= w_acc_nxt;
          r_err    <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = (r_state == S_RUN);
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_result  = r_result;
  assign o_rd_data = r_result[8*i_rd_byte +: 8];

endmodule

// File: tb/tb_intercal_alu_seq.sv
// Purpose : directed self-checking bench for intercal_alu_seq at WIDTH = 32.
// Latency : checks 1-edge ops and the 32-cycle select window.
// Backpr. : exercises writes/starts ignored while busy.
module tb_intercal_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_b;
  logic [1:0]  wr_byte;
  logic [7:0]  wr_data;
  logic        start;
  logic [2:0]  op;
  logic        busy, done, err;
  logic [31:0] result;
  logic [1:0]  rd_byte;
  logic [7:0]  rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  intercal_alu_seq #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_b(wr_b),
    .i_wr_byte(wr_byte), .i_wr_data(wr_data), .i_start(start), .i_op(op),
    .o_busy(busy), .o_done(done), .o_err(err), .o_result(result),
    .i_rd_byte(rd_byte), .o_rd_data(rd_data)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic is_b, input logic [31:0] val);
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_b    = is_b;
      wr_byte = 2'(i);
      wr_data = val[8*i +: 8];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] o);
    start = 1'b1;
    op    = o;
    tick();
    start = 1'b0;
  endtask

  // Runs from the sample after the select start edge until busy falls.
  // Optionally disturbs the DUT with a B write and a second start mid-run.
  task automatic wait_select(input bit inject, output int busy_cycles,
                             output int dones, output logic done_at_fall);
    busy_cycles = 0;
    dones       = 0;
    while (busy && busy_cycles < 200) begin
      busy_cycles++;
      if (inject && busy_cycles == 5) begin
        wr_en = 1'b1; wr_b = 1'b1; wr_byte = 2'd0; wr_data = 8'hFF;
        start = 1'b1; op = 3'd0;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      if (done) dones++;
    end
    done_at_fall = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rd_byte = 2'd0;
    #1;
    n_checks++;
    if ({busy, done, err} !== 3'b000)
      $display("FAIL reset_flags got=%b required=000", {busy, done, err});
    else n_pass++;
    n_checks++;
    if (result !== 32'h0) $display("FAIL reset_result got=%h required=00000000", result);
    else n_pass++;
  endtask

  task automatic test_mingle();
    load(1'b0, 32'h0000FFFF);
    load(1'b1, 32'h00000000);
    pulse_start(3'd0);
    n_checks++;
    if (done !== 1'b1 || result !== 32'hAAAAAAAA || err !== 1'b0)
      $display("FAIL mingle_basic got done=%b res=%h err=%b required done=1 res=aaaaaaaa err=0",
               done, result, err);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL mingle_done_pulse got=%b required=0", done);
    else n_pass++;
    load(1'b0, 32'h00010000);
    pulse_start(3'd0);
    n_checks++;
    if (result !== 32'h0 || err !== 1'b1)
      $display("FAIL mingle_err got res=%h err=%b required res=00000000 err=1", result, err);
    else n_pass++;
  endtask

  task automatic test_unary();
    logic [31:0] a_tab [5]   = '{32'h80000001, 32'h80000001, 32'h80000001, 32'h00000001, 32'h00000001};
    logic [2:0]  op_tab [5]  = '{3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
    logic [31:0] exp_tab [5] = '{32'h80000000, 32'hC0000001, 32'h40000001, 32'h80000001, 32'h80000001};
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 3) load(1'b0, a_tab[i]);
      pulse_start(op_tab[i]);
      n_checks++;
      if (done !== 1'b1 || result !== exp_tab[i] || err !== 1'b0)
        $display("FAIL unary_%0d got done=%b res=%h err=%b required done=1 res=%h err=0",
                 i, done, result, err, exp_tab[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reserved();
    pulse_start(3'd6);
    n_checks++;
    if (done !== 1'b1 || result !== 32'h0 || err !== 1'b1)
      $display("FAIL reserved_op got done=%b res=%h err=%b required done=1 res=00000000 err=1",
               done, result, err);
    else n_pass++;
  endtask

  task automatic test_select();
    int bc, nd;
    logic df;
    load(1'b0, 32'h000000B5);
    load(1'b1, 32'h000000F0);
    pulse_start(3'd1);
    wait_select(1'b0, bc, nd, df);
    n_checks++;
    if (bc !== 32 || nd !== 1 || df !== 1'b1)
      $display("FAIL select_timing got busy=%0d dones=%0d done_at_fall=%b required busy=32 dones=1 done_at_fall=1",
               bc, nd, df);
    else n_pass++;
    n_checks++;
    if (result !== 32'h0000000B || err !== 1'b0)
      $display("FAIL select_b5_f0 got res=%h err=%b required res=0000000b err=0", result, err);
    else n_pass++;
    load(1'b0, 32'h12345678);
    load(1'b1, 32'hFFFFFFFF);
    pulse_start(3'd1);
    wait_select(1'b0, bc, nd, df);
    n_checks++;
    if (result !== 32'h12345678) $display("FAIL select_all got=%h required=12345678", result);
    else n_pass++;
  endtask

  task automatic test_protect();
    int bc, nd;
    logic df;
    load(1'b0, 32'h000000B5);
    load(1'b1, 32'h000000F0);
    pulse_start(3'd1);
    wait_select(1'b1, bc, nd, df);
    n_checks++;
    if (bc !== 32 || nd !== 1 || result !== 32'h0000000B)
      $display("FAIL protect_run got busy=%0d dones=%0d res=%h required busy=32 dones=1 res=0000000b",
               bc, nd, result);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL protect_no_extra_done got=%b required=0", done);
    else n_pass++;
    // B must still be 0xF0; a leaked 0xFF write would select all of 0xB5.
    pulse_start(3'd1);
    wait_select(1'b0, bc, nd, df);
    n_checks++;
    if (result !== 32'h0000000B) $display("FAIL protect_b_kept got=%h required=0000000b", result);
    else n_pass++;
  endtask

  task automatic test_reset_mid_select();
    int nd = 0;
    load(1'b0, 32'h000000B5);
    load(1'b1, 32'h000000F0);
    pulse_start(3'd1);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, err} !== 3'b000 || result !== 32'h0)
      $display("FAIL reset_mid_run got busy=%b done=%b err=%b res=%h required 0 0 0 00000000",
               busy, done, err, result);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) nd++;
    end
    n_checks++;
    if (nd !== 0) $display("FAIL reset_no_done got=%0d required=0", nd);
    else n_pass++;
    // A and B cleared: mingle of zeros is zero with no error.
    pulse_start(3'd0);
    n_checks++;
    if (result !== 32'h0 || err !== 1'b0)
      $display("FAIL reset_operands got res=%h err=%b required res=00000000 err=0", result, err);
    else n_pass++;
  endtask

  task automatic test_readback();
    int bc, nd;
    logic df;
    logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(1'b0, 32'hDEADBEEF);
    load(1'b1, 32'hFFFFFFFF);
    pulse_start(3'd1);
    wait_select(1'b0, bc, nd, df);
    n_checks++;
    if (result !== 32'hDEADBEEF) $display("FAIL readback_result got=%h required=deadbeef", result);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_byte = 2'(i);
      #1;
      n_checks++;
      if (rd_data !== exp_b[i])
        $display("FAIL readback_byte%0d got=%h required=%h", i, rd_data, exp_b[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    load(1'b0, 32'h0000FFFF);
    load(1'b1, 32'h00000000);
    // Write A byte 0 and start mingle on the same edge: old A is used.
    wr_en = 1'b1; wr_b = 1'b0; wr_byte = 2'd0; wr_data = 8'h00;
    start = 1'b1; op = 3'd0;
    tick();
    wr_en = 1'b0; start = 1'b0;
    n_checks++;
    if (result !== 32'hAAAAAAAA) $display("FAIL wr_start_old got=%h required=aaaaaaaa", result);
    else n_pass++;
    pulse_start(3'd0);
    n_checks++;
    if (result !== 32'hAAAA0000) $display("FAIL wr_start_new got=%h required=aaaa0000", result);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_b = 1'b0; wr_byte = 2'd0; wr_data = 8'h00;
    start = 1'b0; op = 3'd0; rd_byte = 2'd0;
    test_reset();
    test_mingle();
    test_unary();
    test_reserved();
    test_select();
    test_protect();
    test_reset_mid_select();
    test_readback();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
